// File: rtl/parity_check_rx_if.sv
// Signal bundle between the serial line / byte consumer and parity_check_rx.
// Carries the bit strobe, the valid/ready byte output and the status readback.
interface parity_check_rx_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) ();
    logic              bit_en;
    logic              serial_in;
    logic              out_ready;
    logic              clr_stats;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_par_err;
    logic              out_frm_err;
    logic              busy;
    logic [CNT_W-1:0]  err_count;
    logic              overrun;

    // Line driver and byte consumer
    modport master (
        output bit_en, serial_in, out_ready, clr_stats,
        input  out_valid, out_data, out_par_err, out_frm_err, busy, err_count, overrun
    );

    // Receiver
    modport slave (
        input  bit_en, serial_in, out_ready, clr_stats,
        output out_valid, out_data, out_par_err, out_frm_err, busy, err_count, overrun
    );
endinterface

// File: rtl/parity_check_rx.sv
// Serial deframer for start/data/parity/stop frames with parity recheck,
// valid/ready byte output, saturating error counter and sticky overrun flag.
module parity_check_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    parity_check_rx_if.slave rx_bus
);
    localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]        state_q,       state_d;
    logic [IDX_W-1:0]  idx_q,         idx_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic              acc_q,         acc_d;
    logic              par_err_q,     par_err_d;
    logic              busy_q,        busy_d;
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic              out_par_err_q, out_par_err_d;
    logic              out_frm_err_q, out_frm_err_d;
    logic [CNT_W-1:0]  err_cnt_q,     err_cnt_d;
    logic              overrun_q,     overrun_d;

    logic              frame_done_c;
    logic              stop_err_c;
    logic              accept_c;
    logic              load_c;
    logic              frame_bad_c;

    // Deframer: only bit_en cycles move the FSM; everything else holds
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        par_err_d    = par_err_q;
        frame_done_c = 1'b0;
        stop_err_c   = 1'b0;

        if (rx_bus.bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_bus.serial_in) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d[idx_q] = rx_bus.serial_in;
                    acc_d          = acc_q ^ rx_bus.serial_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    par_err_d = ((acc_q ^ rx_bus.serial_in) != ODD_BIT);
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    // A low stop bit is flagged but the hunt restarts at the next strobe
                    frame_done_c = 1'b1;
                    stop_err_c   = ~rx_bus.serial_in;
                    state_d      = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output holding register and status counters
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_par_err_d = out_par_err_q;
        out_frm_err_d = out_frm_err_q;
        err_cnt_d     = err_cnt_q;
        overrun_d     = overrun_q;
        busy_d        = (state_d != S_IDLE);

        accept_c    = out_valid_q & rx_bus.out_ready;
        load_c      = frame_done_c & (~out_valid_q | rx_bus.out_ready);
        frame_bad_c = par_err_q | stop_err_c;

        if (load_c) begin
            out_valid_d   = 1'b1;
            out_data_d    = shift_q;
            out_par_err_d = par_err_q;
            out_frm_err_d = stop_err_c;
        end else if (accept_c) begin
            out_valid_d = 1'b0;
        end

        // Completed frame with the previous byte still unaccepted is dropped
        if (frame_done_c && out_valid_q && !rx_bus.out_ready) begin
            overrun_d = 1'b1;
        end

        if (frame_done_c && frame_bad_c && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        if (rx_bus.clr_stats) begin
            err_cnt_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            acc_q         <= 1'b0;
            par_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_par_err_q <= 1'b0;
            out_frm_err_q <= 1'b0;
            err_cnt_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            acc_q         <= acc_d;
            par_err_q     <= par_err_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_par_err_q <= out_par_err_d;
            out_frm_err_q <= out_frm_err_d;
            err_cnt_q     <= err_cnt_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_bus.out_valid   = out_valid_q;
    assign rx_bus.out_data    = out_data_q;
    assign rx_bus.out_par_err = out_par_err_q;
    assign rx_bus.out_frm_err = out_frm_err_q;
    assign rx_bus.busy        = busy_q;
    assign rx_bus.err_count   = err_cnt_q;
    assign rx_bus.overrun     = overrun_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: three instances (even/8-bit count, odd, even/2-bit count)
// share one stimulus stream and are checked against a frame-level reference model.
module tb_parity_check_rx;
    localparam int unsigned DATA_W = 8;
    localparam int          NDUT   = 3;
    localparam int unsigned VEC_W  = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst       = 1'b1;
    logic bit_en    = 1'b0;
    logic serial_in = 1'b1;
    logic out_ready = 1'b0;
    logic clr_stats = 1'b0;

    parity_check_rx_if #(.DATA_W(DATA_W), .CNT_W(8)) if_e ();
    parity_check_rx_if #(.DATA_W(DATA_W), .CNT_W(8)) if_o ();
    parity_check_rx_if #(.DATA_W(DATA_W), .CNT_W(2)) if_s ();

    parity_check_rx #(.DATA_W(DATA_W), .PARITY_ODD(0), .CNT_W(8)) u_even (.clk(clk), .rst(rst), .rx_bus(if_e));
    parity_check_rx #(.DATA_W(DATA_W), .PARITY_ODD(1), .CNT_W(8)) u_odd  (.clk(clk), .rst(rst), .rx_bus(if_o));
    parity_check_rx #(.DATA_W(DATA_W), .PARITY_ODD(0), .CNT_W(2)) u_sat  (.clk(clk), .rst(rst), .rx_bus(if_s));

    assign if_e.bit_en = bit_en;  assign if_e.serial_in = serial_in;
    assign if_e.out_ready = out_ready;  assign if_e.clr_stats = clr_stats;
    assign if_o.bit_en = bit_en;  assign if_o.serial_in = serial_in;
    assign if_o.out_ready = out_ready;  assign if_o.clr_stats = clr_stats;
    assign if_s.bit_en = bit_en;  assign if_s.serial_in = serial_in;
    assign if_s.out_ready = out_ready;  assign if_s.clr_stats = clr_stats;

    logic              o_valid [NDUT];
    logic [DATA_W-1:0] o_data  [NDUT];
    logic              o_perr  [NDUT];
    logic              o_ferr  [NDUT];
    logic [7:0]        o_cnt   [NDUT];
    logic              o_ovr   [NDUT];
    logic              o_busy  [NDUT];

    assign o_valid[0] = if_e.out_valid;   assign o_valid[1] = if_o.out_valid;   assign o_valid[2] = if_s.out_valid;
    assign o_data[0]  = if_e.out_data;    assign o_data[1]  = if_o.out_data;    assign o_data[2]  = if_s.out_data;
    assign o_perr[0]  = if_e.out_par_err; assign o_perr[1]  = if_o.out_par_err; assign o_perr[2]  = if_s.out_par_err;
    assign o_ferr[0]  = if_e.out_frm_err; assign o_ferr[1]  = if_o.out_frm_err; assign o_ferr[2]  = if_s.out_frm_err;
    assign o_cnt[0]   = if_e.err_count;   assign o_cnt[1]   = if_o.err_count;   assign o_cnt[2]   = 8'(if_s.err_count);
    assign o_ovr[0]   = if_e.overrun;     assign o_ovr[1]   = if_o.overrun;     assign o_ovr[2]   = if_s.overrun;
    assign o_busy[0]  = if_e.busy;        assign o_busy[1]  = if_o.busy;        assign o_busy[2]  = if_s.busy;

    // Reference model: per-instance configuration and expected visible state
    bit                odd_cfg [NDUT] = '{1'b0, 1'b1, 1'b0};
    int                cmax    [NDUT] = '{255, 255, 3};
    logic              m_have  [NDUT];
    logic [DATA_W-1:0] m_data  [NDUT];
    logic              m_perr  [NDUT];
    logic              m_ferr  [NDUT];
    int                m_cnt   [NDUT];
    logic              m_ovr   [NDUT];
    logic              in_frame;
    logic              rxq [$];

    int passed = 0;
    int total  = 0;

    function automatic logic [VEC_W-1:0] obs_vec(input int k);
        return {o_valid[k], o_data[k], o_perr[k], o_ferr[k], o_cnt[k], o_ovr[k], o_busy[k]};
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec(input int k);
        return {m_have[k], m_data[k], m_perr[k], m_ferr[k], 8'(m_cnt[k]), m_ovr[k], in_frame};
    endfunction

    function automatic logic [DATA_W+2:0] frame_bits(input logic [DATA_W-1:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Advance the model on the inputs of this cycle, then clock the DUTs
    task automatic cycle();
        logic [DATA_W-1:0] d;
        logic p, s, pe, fe, done;
        d = '0; p = 1'b0; s = 1'b1; done = 1'b0;
        if (rst) begin
            in_frame = 1'b0;
            rxq.delete();
            for (int k = 0; k < NDUT; k++) begin
                m_have[k] = 1'b0; m_data[k] = '0; m_perr[k] = 1'b0;
                m_ferr[k] = 1'b0; m_cnt[k] = 0; m_ovr[k] = 1'b0;
            end
        end else begin
            if (bit_en) begin
                if (!in_frame) begin
                    if (serial_in == 1'b0) begin
                        in_frame = 1'b1;
                        rxq.delete();
                    end
                end else begin
                    rxq.push_back(serial_in);
                    if (rxq.size() == int'(DATA_W) + 2) begin
                        done = 1'b1;
                        in_frame = 1'b0;
                    end
                end
            end
            if (done) begin
                for (int i = 0; i < int'(DATA_W); i++) d[i] = rxq[i];
                p = rxq[DATA_W];
                s = rxq[DATA_W + 1];
            end
            for (int k = 0; k < NDUT; k++) begin
                if (done) begin
                    pe = (((^d) ^ p) != odd_cfg[k]);
                    fe = !s;
                    if (m_have[k] && !out_ready) begin
                        m_ovr[k] = 1'b1;
                    end else begin
                        m_have[k] = 1'b1; m_data[k] = d; m_perr[k] = pe; m_ferr[k] = fe;
                    end
                    if ((pe || fe) && m_cnt[k] < cmax[k]) m_cnt[k]++;
                end else if (m_have[k] && out_ready) begin
                    m_have[k] = 1'b0;
                end
                if (clr_stats) begin
                    m_cnt[k] = 0;
                    m_ovr[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int gap);
        bit_en = 1'b1;
        serial_in = b;
        cycle();
        bit_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            serial_in = 1'($urandom);
            cycle();
        end
        serial_in = 1'b1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s, input int gmin, input int gmax);
        logic [DATA_W+2:0] fb;
        fb = frame_bits(d, p, s);
        for (int i = 0; i < int'(DATA_W) + 3; i++)
            drive_bit(fb[i], (i == int'(DATA_W) + 2) ? 0 : int'($urandom_range(32'(gmax), 32'(gmin))));
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        serial_in = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_en = 1'b0; serial_in = 1'b1; out_ready = 1'b0; clr_stats = 1'b0;
        cycle();
        bit_en = 1'b1; serial_in = 1'b0;
        cycle();
        rst = 1'b0; bit_en = 1'b0; serial_in = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if ({o_valid[k], o_data[k], o_perr[k], o_ferr[k], o_busy[k], o_cnt[k], o_ovr[k]} !== '0)
                $display("FAIL reset_state dut%0d: got %h want 0", k, obs_vec(k));
            else passed++;
        end
    endtask

    task automatic test_good_frame();
        out_ready = 1'b1;
        send_frame(8'h53, 1'b0, 1'b1, 0, 0);
        total++;
        if ({o_valid[0], o_data[0], o_perr[0], o_ferr[0], o_cnt[0]} !== {1'b1, 8'h53, 1'b0, 1'b0, 8'd0})
            $display("FAIL good_frame: got v=%b d=%h pe=%b fe=%b cnt=%0d want v=1 d=53 pe=0 fe=0 cnt=0",
                     o_valid[0], o_data[0], o_perr[0], o_ferr[0], o_cnt[0]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL good_frame_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        idle(1);
        total++;
        if (o_valid[0] !== 1'b0) $display("FAIL good_frame_valid_drop: got %b want 0", o_valid[0]);
        else passed++;
    endtask

    task automatic test_parity_error();
        out_ready = 1'b1;
        send_frame(8'h53, 1'b1, 1'b1, 0, 1);
        total++;
        if ({o_data[0], o_perr[0], o_cnt[0]} !== {8'h53, 1'b1, 8'd1})
            $display("FAIL parity_err_even: got d=%h pe=%b cnt=%0d want d=53 pe=1 cnt=1", o_data[0], o_perr[0], o_cnt[0]);
        else passed++;
        total++;
        if ({o_data[1], o_perr[1]} !== {8'h53, 1'b0})
            $display("FAIL parity_ok_odd: got d=%h pe=%b want d=53 pe=0", o_data[1], o_perr[1]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL parity_err_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        idle(2);
    endtask

    task automatic test_framing_error();
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
        total++;
        if ({o_data[0], o_perr[0], o_ferr[0], o_cnt[0]} !== {8'hA5, 1'b0, 1'b1, 8'd2})
            $display("FAIL framing_err: got d=%h pe=%b fe=%b cnt=%0d want d=a5 pe=0 fe=1 cnt=2",
                     o_data[0], o_perr[0], o_ferr[0], o_cnt[0]);
        else passed++;
        send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
        total++;
        if ({o_valid[0], o_data[0], o_perr[0], o_ferr[0], o_cnt[0]} !== {1'b1, 8'h3C, 1'b0, 1'b0, 8'd2})
            $display("FAIL framing_recover: got v=%b d=%h pe=%b fe=%b cnt=%0d want v=1 d=3c pe=0 fe=0 cnt=2",
                     o_valid[0], o_data[0], o_perr[0], o_ferr[0], o_cnt[0]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL framing_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        idle(2);
    endtask

    task automatic test_overrun();
        logic [DATA_W+2:0] fb;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 2);
        send_frame(8'h22, 1'b0, 1'b1, 0, 2);
        total++;
        if ({o_valid[0], o_data[0], o_ovr[0]} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL overrun_hold: got v=%b d=%h ovr=%b want v=1 d=11 ovr=1", o_valid[0], o_data[0], o_ovr[0]);
        else passed++;
        out_ready = 1'b1;
        idle(3);
        total++;
        if ({o_valid[0], o_data[0], o_ovr[0]} !== {1'b0, 8'h11, 1'b1})
            $display("FAIL overrun_drain: got v=%b d=%h ovr=%b want v=0 d=11 ovr=1", o_valid[0], o_data[0], o_ovr[0]);
        else passed++;
        clr_stats = 1'b1;
        idle(1);
        clr_stats = 1'b0;
        total++;
        if ({o_ovr[0], o_cnt[0]} !== {1'b0, 8'd0})
            $display("FAIL overrun_clear: got ovr=%b cnt=%0d want ovr=0 cnt=0", o_ovr[0], o_cnt[0]);
        else passed++;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 0);
        fb = frame_bits(8'h22, 1'b0, 1'b1);
        for (int i = 0; i < int'(DATA_W) + 2; i++) drive_bit(fb[i], 0);
        out_ready = 1'b1;
        drive_bit(fb[DATA_W + 2], 0);
        out_ready = 1'b0;
        total++;
        if ({o_valid[0], o_data[0], o_ovr[0]} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL overrun_simul: got v=%b d=%h ovr=%b want v=1 d=22 ovr=0", o_valid[0], o_data[0], o_ovr[0]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL overrun_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        out_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 0, 0);
        drive_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1);
        total++;
        if ({o_busy[0], o_valid[0]} !== 2'b11)
            $display("FAIL mid_frame_busy: got busy=%b v=%b want busy=1 v=1", o_busy[0], o_valid[0]);
        else passed++;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++;
        if ({o_busy[0], o_valid[0], o_ovr[0], o_cnt[0]} !== {1'b0, 1'b0, 1'b0, 8'd0})
            $display("FAIL mid_frame_reset: got busy=%b v=%b ovr=%b cnt=%0d want all 0", o_busy[0], o_valid[0], o_ovr[0], o_cnt[0]);
        else passed++;
        out_ready = 1'b1;
        send_frame(8'h0F, 1'b0, 1'b1, 0, 2);
        total++;
        if ({o_valid[0], o_data[0], o_perr[0], o_ferr[0]} !== {1'b1, 8'h0F, 1'b0, 1'b0})
            $display("FAIL after_reset_frame: got v=%b d=%h pe=%b fe=%b want v=1 d=0f pe=0 fe=0",
                     o_valid[0], o_data[0], o_perr[0], o_ferr[0]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL reset_mid_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        idle(1);
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] d;
        logic [DATA_W+2:0] fb;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            d = DATA_W'($urandom);
            send_frame(d, ~(^d), 1'b1, 0, 2);
            idle(1);
        end
        total++;
        if ({o_cnt[2], o_cnt[0]} !== {8'd3, 8'd5})
            $display("FAIL saturation: got cnt2=%0d cnt8=%0d want cnt2=3 cnt8=5", o_cnt[2], o_cnt[0]);
        else passed++;
        d = DATA_W'($urandom);
        fb = frame_bits(d, ~(^d), 1'b1);
        for (int i = 0; i < int'(DATA_W) + 2; i++) drive_bit(fb[i], 0);
        clr_stats = 1'b1;
        drive_bit(fb[DATA_W + 2], 0);
        clr_stats = 1'b0;
        total++;
        if ({o_cnt[2], o_cnt[0]} !== {8'd0, 8'd0})
            $display("FAIL clear_wins: got cnt2=%0d cnt8=%0d want 0 0", o_cnt[2], o_cnt[0]);
        else passed++;
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k)) $display("FAIL saturation_model dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        idle(1);
    endtask

    task automatic test_gaps();
        logic [DATA_W-1:0] d;
        logic p;
        d = DATA_W'($urandom);
        p = 1'($urandom);
        out_ready = 1'b1;
        for (int g = 0; g <= 5; g++) begin
            send_frame(d, p, 1'b1, g, g);
            total++;
            if ({o_valid[0], o_data[0], o_perr[0], o_ferr[0]} !== {1'b1, d, (^d) ^ p, 1'b0})
                $display("FAIL gap%0d: got v=%b d=%h pe=%b fe=%b want v=1 d=%h pe=%b fe=0",
                         g, o_valid[0], o_data[0], o_perr[0], o_ferr[0], d, (^d) ^ p);
            else passed++;
            idle(2);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 40; n++) begin
            d = DATA_W'($urandom);
            out_ready = 1'($urandom);
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) drive_bit(1'b1, 0);
            send_frame(d, 1'($urandom), ($urandom_range(3, 0) != 0), 0, 3);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) $display("FAIL random%0d dut%0d: got %h want %h", n, k, obs_vec(k), exp_vec(k));
                else passed++;
            end
            clr_stats = ($urandom_range(7, 0) == 0);
            idle(1);
            clr_stats = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_overrun();
        test_reset_mid_frame();
        test_saturation();
        test_gaps();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
